// File: rtl/countdown_time_controller.sv
// MM:SS BCD countdown sequencer for the doomsday clock: set/run/pause/expired
// state machine driven by debounced button pulses and a 1 Hz tick.
module countdown_time_controller #(
    parameter logic [15:0] RESET_TIME   = 16'h0500,
    parameter int          SEC_TENS_MAX = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_pulse,
    input  logic        inc_pulse,
    input  logic        start_pulse,
    input  logic        tick,
    output logic [15:0] time_bcd,
    output logic [1:0]  digit_sel,
    output logic        setting,
    output logic        running,
    output logic        expired,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET     = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_EXPIRED = 3'd4
    } state_t;

    localparam logic [3:0] SEC_TENS_MAX_C = 4'(SEC_TENS_MAX);

    // Increment one BCD digit, wrapping past max back to zero.
    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
        logic [3:0] r;
        if (d >= max) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    // One-second MM:SS decrement with borrow chain; caller guarantees non-zero input.
    function automatic logic [15:0] time_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0) begin
                r[7:4] = t[7:4] - 4'd1;
            end else begin
                r[7:4] = SEC_TENS_MAX_C;
                if (t[11:8] != 4'd0) begin
                    r[11:8] = t[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    state_t      state_r, state_s;
    logic [15:0] time_r, time_s, dec_s;
    logic [1:0]  sel_r, sel_s;
    logic        setting_r, running_r, expired_r;

    // Next-state, next-time and next-digit-select decode.
    always_comb begin
        state_s = state_r;
        time_s  = time_r;
        sel_s   = sel_r;
        dec_s   = time_dec(time_r);
        case (state_r)
            ST_IDLE: begin
                if (mode_pulse) begin
                    state_s = ST_SET;
                    sel_s   = 2'd3;
                end else if (start_pulse && (time_r != 16'h0000)) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SET: begin
                if (inc_pulse) begin
                    case (sel_r)
                        2'd0:    time_s[3:0]   = digit_inc(time_r[3:0], 4'd9);
                        2'd1:    time_s[7:4]   = digit_inc(time_r[7:4], SEC_TENS_MAX_C);
                        2'd2:    time_s[11:8]  = digit_inc(time_r[11:8], 4'd9);
                        2'd3:    time_s[15:12] = digit_inc(time_r[15:12], 4'd9);
                        default: time_s        = time_r;
                    endcase
                end else begin
                    time_s = time_r;
                end
                if (mode_pulse) begin
                    if (sel_r != 2'd0) begin
                        sel_s = sel_r - 2'd1;
                    end else begin
                        state_s = ST_IDLE;
                        sel_s   = 2'd3;
                    end
                end else begin
                    sel_s = sel_r;
                end
            end
            ST_RUN: begin
                // A zero result beats a simultaneous pause request.
                if (tick) begin
                    time_s = dec_s;
                    if (dec_s == 16'h0000) begin
                        state_s = ST_EXPIRED;
                    end else if (start_pulse) begin
                        state_s = ST_PAUSED;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else if (start_pulse) begin
                    state_s = ST_PAUSED;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PAUSED: begin
                if (mode_pulse) begin
                    state_s = ST_SET;
                    sel_s   = 2'd3;
                end else if (start_pulse) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_PAUSED;
                end
            end
            ST_EXPIRED: begin
                time_s = 16'h0000;
                if (start_pulse || mode_pulse) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_EXPIRED;
                end
            end
            default: begin
                state_s = ST_IDLE;
                sel_s   = 2'd3;
            end
        endcase
    end

    // State, time and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            time_r    <= RESET_TIME;
            sel_r     <= 2'd3;
            setting_r <= 1'b0;
            running_r <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            time_r    <= time_s;
            sel_r     <= sel_s;
            setting_r <= (state_s == ST_SET);
            running_r <= (state_s == ST_RUN);
            expired_r <= (state_s == ST_EXPIRED);
        end
    end

    assign time_bcd  = time_r;
    assign digit_sel = sel_r;
    assign setting   = setting_r;
    assign running   = running_r;
    assign expired   = expired_r;
    assign state     = state_r;

endmodule

// File: tb/tb_countdown_time_controller.sv
// Directed bench for countdown_time_controller: vector table plus hand sequences
// for countdown, pause, simultaneous-event and reset corners.
module tb_countdown_time_controller;

    logic        clk = 1'b0;
    logic        rst, mode_pulse, inc_pulse, start_pulse, tick;
    logic [15:0] time_bcd;
    logic [1:0]  digit_sel;
    logic        setting, running, expired;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    countdown_time_controller dut (
        .clk(clk), .rst(rst), .mode_pulse(mode_pulse), .inc_pulse(inc_pulse),
        .start_pulse(start_pulse), .tick(tick), .time_bcd(time_bcd),
        .digit_sel(digit_sel), .setting(setting), .running(running),
        .expired(expired), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        m, i, s, t;
        int          reps;
        logic [15:0] t_exp;
        logic [2:0]  st_exp;
        logic [1:0]  sel_exp;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input logic [15:0] t_exp,
                         input logic [2:0] st_exp, input logic [1:0] sel_exp);
        logic [22:0] act, exp;
        act = {time_bcd, digit_sel, state, setting, running, expired};
        exp = {t_exp, sel_exp, st_exp, (st_exp == 3'd1), (st_exp == 3'd2), (st_exp == 3'd4)};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got time=%h sel=%0d state=%0d set/run/exp=%b%b%b, want time=%h sel=%0d state=%0d set/run/exp=%b%b%b",
                     name, time_bcd, digit_sel, state, setting, running, expired,
                     t_exp, sel_exp, st_exp, exp[2], exp[1], exp[0]);
        end
    endtask

    // One-cycle pulse of the chosen inputs; returns #1 after the capturing edge.
    task automatic pulse(input logic m, input logic i, input logic s, input logic t);
        @(negedge clk);
        mode_pulse = m; inc_pulse = i; start_pulse = s; tick = t;
        @(posedge clk);
        #1;
        mode_pulse = 1'b0; inc_pulse = 1'b0; start_pulse = 1'b0; tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // From IDLE with time cur, walk all four digits and end in IDLE with time tgt.
    task automatic set_time(input logic [15:0] cur, input logic [15:0] tgt);
        int n, lim, c, g;
        for (int d = 3; d >= 0; d--) begin
            pulse(1'b1, 1'b0, 1'b0, 1'b0);
            lim = (d == 1) ? 6 : 10;
            c = int'(cur[d*4 +: 4]);
            g = int'(tgt[d*4 +: 4]);
            n = (g - c + lim) % lim;
            for (int k = 0; k < n; k++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; mode_pulse = 1'b0; inc_pulse = 1'b0; start_pulse = 1'b0; tick = 1'b0;

        //            m     i     s     t    reps  time      state  sel
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  16'h0500, 3'd1, 2'd3};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7,  16'h7500, 3'd1, 2'd3};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  16'h7500, 3'd1, 2'd2};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2,  16'h7700, 3'd1, 2'd2};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  16'h7700, 3'd1, 2'd1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6,  16'h7700, 3'd1, 2'd1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  16'h7700, 3'd1, 2'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 16'h7700, 3'd1, 2'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  16'h7700, 3'd0, 2'd3};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1,  16'h7700, 3'd1, 2'd3};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4,  16'h7700, 3'd0, 2'd3};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1,  16'h7700, 3'd0, 2'd3};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  16'h7700, 3'd2, 2'd3};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1,  16'h7659, 3'd2, 2'd3};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,  16'h7659, 3'd2, 2'd3};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  16'h7659, 3'd3, 2'd3};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 3,  16'h7659, 3'd3, 2'd3};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  16'h7659, 3'd2, 2'd3};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 60, 16'h7559, 3'd2, 2'd3};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  16'h7559, 3'd3, 2'd3};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 1,  16'h7559, 3'd1, 2'd3};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  16'h7559, 3'd1, 2'd3};
        vecs[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 4,  16'h7559, 3'd0, 2'd3};

        do_reset();
        check("reset", 16'h0500, 3'd0, 2'd3);

        for (int v = 0; v < 23; v++) begin
            for (int r = 0; r < vecs[v].reps; r++)
                pulse(vecs[v].m, vecs[v].i, vecs[v].s, vecs[v].t);
            check($sformatf("vec%0d", v), vecs[v].t_exp, vecs[v].st_exp, vecs[v].sel_exp);
        end

        // Full countdown from 01:00 to expiry, then acknowledge and refuse to start at zero.
        do_reset();
        set_time(16'h0500, 16'h0100);
        check("set_0100", 16'h0100, 3'd0, 2'd3);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("tick_0059", 16'h0059, 3'd2, 2'd3);
        for (int k = 0; k < 58; k++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("tick_0001", 16'h0001, 3'd2, 2'd3);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("expire", 16'h0000, 3'd4, 2'd3);
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        check("expired_hold", 16'h0000, 3'd4, 2'd3);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("ack_idle", 16'h0000, 3'd0, 2'd3);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("start_at_zero", 16'h0000, 3'd0, 2'd3);

        // Pause at 02:30 freezes time.
        do_reset();
        set_time(16'h0500, 16'h0230);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("pause_0230", 16'h0230, 3'd3, 2'd3);
        for (int k = 0; k < 3; k++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("paused_frozen", 16'h0230, 3'd3, 2'd3);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("resume_0229", 16'h0229, 3'd2, 2'd3);

        // Tick and start together at 00:01: expiry wins over pause.
        do_reset();
        set_time(16'h0500, 16'h0001);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("run_0001", 16'h0001, 3'd2, 2'd3);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        check("tick_start_expire", 16'h0000, 3'd4, 2'd3);

        // Increment and advance together on min ones = 9.
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("min_ones_9", 16'h0900, 3'd1, 2'd2);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check("inc_mode_same", 16'h0000, 3'd1, 2'd1);

        // Reset mid-countdown.
        do_reset();
        set_time(16'h0500, 16'h0310);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("run_0310", 16'h0310, 3'd2, 2'd3);
        do_reset();
        check("reset_in_run", 16'h0500, 3'd0, 2'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
